// File: rtl/eca_array_engine.sv
// Elementary cellular automaton engine: loads a rule, seed and boundary mode, then streams generations 0..gens.
// Optional macro ECA_FIXED_POINT_EN ends a job early once the next generation equals the current one.
module eca_array_engine #(
   parameter int N     = 8,
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [7:0]       load_rule,
   input  logic [N-1:0]     load_state,
   input  logic [1:0]       load_bound,
   input  logic [GEN_W-1:0] load_gens,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_state,
   output logic [GEN_W-1:0] out_gen,
   output logic             done,
   output logic             fixed_pt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       rule_q;
   logic [1:0]       bound_q;
   logic [GEN_W-1:0] gens_q;
   logic             left_edge, right_edge;
   logic [N+1:0]     ext;
   logic [N-1:0]     next_cells;
   logic             beat_acc, last_beat, hit_fixed;

   // Edge neighbours: left of cell N-1 and right of cell 0; mode 11 behaves as wrap.
   always_comb begin
      left_edge  = out_state[0];
      right_edge = out_state[N-1];
      case (bound_q)
         2'b01: begin
            left_edge  = 1'b0;
            right_edge = 1'b0;
         end
         2'b10: begin
            left_edge  = 1'b1;
            right_edge = 1'b1;
         end
         default: ;
      endcase
   end

   assign ext = {left_edge, out_state, right_edge};

   // ext[i] is the right neighbour of cell i, so {L,C,R} is the 3-bit window ending at ext[i+2].
   always_comb begin
      next_cells = '0;
      for (int i = 0; i < N; i++) begin
         next_cells[i] = rule_q[ext[i+2 -: 3]];
      end
   end

`ifdef ECA_FIXED_POINT_EN
   assign hit_fixed = (next_cells == out_state);
`else
   assign hit_fixed = 1'b0;
`endif

   assign beat_acc  = out_valid & out_ready;
   assign last_beat = (out_gen == gens_q) | hit_fixed;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      out_valid  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) state_nxt = RUN;
         end
         RUN: begin
            out_valid = 1'b1;
            if (beat_acc && last_beat) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The final beat leaves out_state/out_gen untouched, so out_gen can never pass gens_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         rule_q    <= '0;
         bound_q   <= '0;
         gens_q    <= '0;
         out_state <= '0;
         out_gen   <= '0;
      end else if (state == IDLE && load_valid) begin
         rule_q    <= load_rule;
         bound_q   <= load_bound;
         gens_q    <= load_gens;
         out_state <= load_state;
         out_gen   <= '0;
      end else if (state == RUN && beat_acc && !last_beat) begin
         out_state <= next_cells;
         out_gen   <= out_gen + GEN_W'(1);
      end
   end

`ifdef ECA_FIXED_POINT_EN
   always_ff @(posedge clk) begin
      if (rst)                                 fixed_pt <= 1'b0;
      else if (state == IDLE && load_valid)    fixed_pt <= 1'b0;
      else if (state == RUN && beat_acc && hit_fixed) fixed_pt <= 1'b1;
   end
`else
   assign fixed_pt = 1'b0;
`endif

endmodule

// File: tb/tb_eca_array_engine.sv
// Scoreboard bench for eca_array_engine: stimulus queues expected beats/done flags, a negedge monitor checks them.
module tb_eca_array_engine;

   localparam int N     = 8;
   localparam int GEN_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             load_valid;
   logic             load_ready;
   logic [7:0]       load_rule;
   logic [N-1:0]     load_state;
   logic [1:0]       load_bound;
   logic [GEN_W-1:0] load_gens;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_state;
   logic [GEN_W-1:0] out_gen;
   logic             done;
   logic             fixed_pt;

   typedef struct {
      logic [N-1:0]     st;
      logic [GEN_W-1:0] gen;
      bit               last;
   } beat_t;

   beat_t beat_q[$];
   bit    done_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    done_seen = 0;

   eca_array_engine #(.N(N), .GEN_W(GEN_W)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_rule(load_rule), .load_state(load_state),
      .load_bound(load_bound), .load_gens(load_gens),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .out_gen(out_gen),
      .done(done), .fixed_pt(fixed_pt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expectBeat(input logic [N-1:0] st, input int gen, input bit last);
      beat_t b;
      b.st   = st;
      b.gen  = GEN_W'(gen);
      b.last = last;
      beat_q.push_back(b);
   endtask

   // Issue one job; expectations must already be queued.
   task automatic applyStimulus(input logic [7:0] rule, input logic [N-1:0] st,
                                input logic [1:0] bound, input int gens);
      int w = 0;
      while (!load_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      if (!load_ready) checkOutput("load_ready_wait", 32'(load_ready), 32'd1);
      load_rule  = rule;
      load_state = st;
      load_bound = bound;
      load_gens  = GEN_W'(gens);
      load_valid = 1'b1;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int start = done_seen;
      int cyc = 0;
      while (done_seen == start && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (done_seen == start) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic waitGen(input int g);
      int cyc = 0;
      while (!(out_valid && out_gen == GEN_W'(g)) && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("wait_gen_reached", 32'(out_gen), 32'(g));
   endtask

   // Monitor: scoreboard pops, stall stability, done placement and width.
   logic             prev_stall = 1'b0;
   logic             prev_last  = 1'b0;
   logic             prev_done  = 1'b0;
   logic [N-1:0]     prev_state;
   logic [GEN_W-1:0] prev_gen;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_last  = 1'b0;
         prev_done  = 1'b0;
      end else begin
         logic this_last;
         this_last = 1'b0;
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_state", 32'(out_state), 32'(prev_state));
            checkOutput("stall_gen", 32'(out_gen), 32'(prev_gen));
         end
         if (out_valid && out_ready) begin
            if (beat_q.size() == 0) begin
               checkOutput("unexpected_beat", 32'(out_state), 32'hFFFF_FFFF);
            end else begin
               beat_t e;
               e = beat_q.pop_front();
               checkOutput("beat_state", 32'(out_state), 32'(e.st));
               checkOutput("beat_gen", 32'(out_gen), 32'(e.gen));
               this_last = e.last;
            end
         end
         if (done) begin
            checkOutput("done_after_last_beat", 32'(prev_last), 32'd1);
            checkOutput("done_out_valid_low", 32'(out_valid), 32'd0);
            if (done_q.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               bit fp;
               fp = done_q.pop_front();
               checkOutput("fixed_pt", 32'(fixed_pt), 32'(fp));
            end
            done_seen++;
         end
         if (prev_done) checkOutput("done_one_cycle", 32'(done), 32'd0);
         prev_stall = out_valid && !out_ready;
         prev_state = out_state;
         prev_gen   = out_gen;
         prev_last  = this_last;
         prev_done  = done;
      end
   end

   task automatic checkResetValues(input string name);
      checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({name, "_out_state"}, 32'(out_state), 32'd0);
      checkOutput({name, "_out_gen"}, 32'(out_gen), 32'd0);
      checkOutput({name, "_done"}, 32'(done), 32'd0);
      checkOutput({name, "_fixed_pt"}, 32'(fixed_pt), 32'd0);
      checkOutput({name, "_load_ready"}, 32'(load_ready), 32'd1);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_rule  = '0;
      load_state = '0;
      load_bound = '0;
      load_gens  = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkResetValues("reset");
      @(posedge clk); #1;

      $display("[TB] rule 90 wrap, single seed, 4 generations");
      expectBeat(8'h10, 0, 0);
      expectBeat(8'h28, 1, 0);
      expectBeat(8'h44, 2, 0);
      expectBeat(8'hAA, 3, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h10, 2'b00, 3);
      waitDone("r90");

      $display("[TB] boundary modes");
      expectBeat(8'h80, 0, 0);
      expectBeat(8'h41, 1, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h80, 2'b00, 1);
      waitDone("wrap");
      expectBeat(8'h80, 0, 0);
      expectBeat(8'h40, 1, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h80, 2'b01, 1);
      waitDone("fixed0");
      expectBeat(8'h00, 0, 0);
      expectBeat(8'h81, 1, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h00, 2'b10, 1);
      waitDone("fixed1");
      expectBeat(8'h80, 0, 0);
      expectBeat(8'h41, 1, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h80, 2'b11, 1);
      waitDone("mode11");

      $display("[TB] gens=0 single beat");
      expectBeat(8'h5A, 0, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd30, 8'h5A, 2'b00, 0);
      waitDone("gens0");

      $display("[TB] rule 30 with backpressure at generation 2");
      expectBeat(8'h10, 0, 0);
      expectBeat(8'h38, 1, 0);
      expectBeat(8'h64, 2, 0);
      expectBeat(8'hDE, 3, 0);
      expectBeat(8'h90, 4, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd30, 8'h10, 2'b00, 4);
      waitGen(2);
      out_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
      waitDone("r30");

      $display("[TB] rule 0 from all ones");
      expectBeat(8'hFF, 0, 0);
`ifdef ECA_FIXED_POINT_EN
      expectBeat(8'h00, 1, 1);
      done_q.push_back(1'b1);
`else
      for (int g = 1; g <= 10; g++) expectBeat(8'h00, g, g == 10);
      done_q.push_back(1'b0);
`endif
      applyStimulus(8'd0, 8'hFF, 2'b00, 10);
      waitDone("r0");

      $display("[TB] reset in the middle of a job");
      expectBeat(8'h10, 0, 0);
      expectBeat(8'h28, 1, 0);
      applyStimulus(8'd90, 8'h10, 2'b00, 5);
      waitGen(2);
      rst = 1'b1;
      beat_q.delete();
      done_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkResetValues("midreset");
      repeat (4) @(posedge clk);
      #1;
      expectBeat(8'h80, 0, 0);
      expectBeat(8'h40, 1, 1);
      done_q.push_back(1'b0);
      applyStimulus(8'd90, 8'h80, 2'b01, 1);
      waitDone("after_reset");

      repeat (3) @(posedge clk);
      checkOutput("beat_q_drained", 32'(beat_q.size()), 32'd0);
      checkOutput("done_q_drained", 32'(done_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eca_array_engine.md
ECA_ARRAY_ENGINE -- requirements
Module: eca_array_engine

Interface
REQ-001 Parameter N, default 8: cell count, N >= 3.
REQ-002 Parameter GEN_W, default 16: generation counter and run-length width.
REQ-003 clk  in  1  clock; every register updates on rising edge only.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_valid  in  1  job request.
REQ-006 load_ready  out  1  engine accepts a job; high only in IDLE.
REQ-007 load_rule  in  8  Wolfram rule number, captured on load handshake.
REQ-008 load_state  in  N  initial cells, bit N-1 leftmost; captured on load handshake.
REQ-009 load_bound  in  2  boundary mode: 00 wrap, 01 fixed 0, 10 fixed 1, 11 treated as wrap; captured on load handshake.
REQ-010 load_gens  in  GEN_W  last generation index to emit, captured on load handshake.
REQ-011 out_valid  out  1  out_state/out_gen hold a generation.
REQ-012 out_ready  in  1  consumer accepts beat.
REQ-013 out_state  out  N  current cells.
REQ-014 out_gen  out  GEN_W  generation index of out_state.
REQ-015 done  out  1  one-cycle pulse after final beat accepted.
REQ-016 fixed_pt  out  1  job ended early on fixed point; valid with done, held until next load.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE: load_ready=1, out_valid=0; load_valid=1 captures all load_* fields, sets out_state=load_state, out_gen=0, fixed_pt=0, next state RUN.
REQ-019 RUN: out_valid=1, load_ready=0; load_valid ignored.
REQ-020 Next cell i = rule[{L,C,R}], with C=state[i], L=state[i+1], R=state[i-1].
REQ-021 L of cell N-1 and R of cell 0: wrap -> state[0] and state[N-1] respectively; fixed 0 -> 0; fixed 1 -> 1.
REQ-022 All N next-cell values computed combinationally from current out_state; no extra latency.
REQ-023 Beat accepted when out_valid and out_ready both 1 in same cycle; on acceptance with out_gen < captured gens: out_state <= next state, out_gen <= out_gen+1.
REQ-024 Accepted beat with out_gen == captured gens: next state DONE; out_state/out_gen hold.
REQ-025 out_valid=1 and out_ready=0: out_state, out_gen, out_valid held stable.
REQ-026 Job emits exactly gens+1 beats (generations 0..gens); gens=0 gives one beat.
REQ-027 out_gen never exceeds captured gens; no counter wrap possible.
REQ-028 DONE: done=1 for exactly one cycle, out_valid=0, next state IDLE; load accepted no earlier than the following cycle.

Reset
REQ-029 rst=1: FSM to IDLE, out_state=0, out_gen=0, out_valid=0, done=0, fixed_pt=0, load_ready=1 on cycle after rst deasserts; captured rule/bound/gens cleared to 0.
REQ-030 rst mid-job: job abandoned, no done pulse, in-flight beat discarded.

Configuration
REQ-031 Macro ECA_FIXED_POINT_EN defined: accepted beat in RUN whose next state equals out_state ends job as per REQ-024 and sets fixed_pt=1 at DONE entry, even if out_gen < gens.
REQ-032 Macro undefined: no comparator; fixed_pt tied 0; job always runs gens+1 beats.

Verification
REQ-033 N=8, rule 90, wrap, state 0x10, gens 3, out_ready=1 -> beats 0x10,0x28,0x44,0xAA with out_gen 0..3, done one cycle after beat 3.
REQ-034 Rule 90, state 0x80, gens 1 -> second beat 0x41 (wrap), 0x40 (fixed 0); rule 90, state 0x00, fixed 1 -> 0x81.
REQ-035 Rule 30, gens 4, out_ready low 5 cycles during gen 2 -> out_state/out_gen/out_valid stable throughout, no beat lost or repeated.
REQ-036 Rule 0, state 0xFF, gens 10 -> with macro: beats 0xFF,0x00, done with fixed_pt=1, last out_gen=1; without: 11 beats, fixed_pt=0.
REQ-037 rst asserted at gen 2 of a 5-gen job -> no done, outputs at reset values, new load accepted and run correctly.
